// File: rtl/pb_axi_err_responder.sv
// AXI4 error responder: completes every write with a B and every read with R beats carrying RespCode.
// Atomics that return data (ATOP) are supported only when PB_AXI_ERR_RSP_ATOP_EN is defined.

package pb_axi_err_responder_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

module pb_axi_err_responder #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter logic [1:0]  RespCode  = 2'b11,
    parameter logic [63:0] ReadData  = 64'hCA11_AB1E_BADC_AB1E,
    parameter type axi_req_t = pb_axi_err_responder_pkg::axi_req_t,
    parameter type axi_rsp_t = pb_axi_err_responder_pkg::axi_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  axi_req_t    axi_req_i,
    output axi_rsp_t    axi_rsp_o,
    output logic        busy_o,
    output logic [15:0] txn_cnt_o
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // ReadData is zero-extended first so the slice works for any DataWidth.
    localparam logic [DataWidth+63:0] RDataWide = {{DataWidth{1'b0}}, ReadData};
    localparam logic [DataWidth-1:0]  RDataExt  = RDataWide[DataWidth-1:0];

    w_state_e           w_state_q, w_state_d;
    r_state_e           r_state_q, r_state_d;
    logic [IdWidth-1:0] w_id_q, w_id_d;
    logic [IdWidth-1:0] r_id_q, r_id_d;
    logic [7:0]         r_cnt_q, r_cnt_d;
    logic [15:0]        txn_cnt_q, txn_cnt_d;
    logic [16:0]        txn_sum;

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic aw_hs, b_hs, r_hs;
    logic aw_gate_ok, atop_pend, r_plain;
    logic unused_req;

    assign unused_req = ^axi_req_i;

`ifdef PB_AXI_ERR_RSP_ATOP_EN
    logic               atop_take;
    logic               atop_pend_q, atop_pend_d;
    logic               r_atop_q, r_atop_d;
    logic [IdWidth-1:0] atop_id_q, atop_id_d;
    logic [7:0]         atop_len_q, atop_len_d;

    // An atomic needing read data waits until the read FSM is free to take it.
    assign aw_gate_ok = !(axi_req_i.aw.atop[5] && ((r_state_q != R_IDLE) || atop_pend_q));
    assign atop_take  = aw_hs && axi_req_i.aw.atop[5];
    assign atop_pend  = atop_pend_q;
    assign r_plain    = !r_atop_q;
`else
    assign aw_gate_ok = 1'b1;
    assign atop_pend  = 1'b0;
    assign r_plain    = 1'b1;
`endif

    assign aw_hs = aw_ready && axi_req_i.aw_valid;
    assign b_hs  = b_valid && axi_req_i.b_ready;
    assign r_hs  = r_valid && axi_req_i.r_ready;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = !rst_i && aw_gate_ok;
                if (aw_ready && axi_req_i.aw_valid) begin
                    w_id_d    = axi_req_i.aw.id;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready = !rst_i;
                if (w_ready && axi_req_i.w_valid && axi_req_i.w.last) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = !rst_i;
                if (b_valid && axi_req_i.b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
`ifdef PB_AXI_ERR_RSP_ATOP_EN
        atop_pend_d = atop_pend_q;
        atop_id_d   = atop_id_q;
        atop_len_d  = atop_len_q;
        r_atop_d    = r_atop_q;
`endif
        case (r_state_q)
            R_IDLE: begin
                ar_ready = !rst_i && !atop_pend;
                if (ar_ready && axi_req_i.ar_valid) begin
                    r_state_d = R_DATA;
                    r_id_d    = axi_req_i.ar.id;
                    r_cnt_d   = axi_req_i.ar.len;
`ifdef PB_AXI_ERR_RSP_ATOP_EN
                    r_atop_d  = 1'b0;
                    // AR wins the tie; the atomic's read half is parked until the AR burst ends.
                    if (atop_take) begin
                        atop_pend_d = 1'b1;
                        atop_id_d   = axi_req_i.aw.id;
                        atop_len_d  = axi_req_i.aw.len;
                    end
                end else if (atop_take) begin
                    r_state_d = R_DATA;
                    r_id_d    = axi_req_i.aw.id;
                    r_cnt_d   = axi_req_i.aw.len;
                    r_atop_d  = 1'b1;
                end else if (atop_pend_q) begin
                    r_state_d   = R_DATA;
                    r_id_d      = atop_id_q;
                    r_cnt_d     = atop_len_q;
                    r_atop_d    = 1'b1;
                    atop_pend_d = 1'b0;
                end
`else
                end
`endif
            end
            R_DATA: begin
                r_valid = !rst_i;
                r_last  = (r_cnt_q == 8'd0);
                if (r_valid && axi_req_i.r_ready) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q - 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Two completions in one cycle add 2; the 17th bit flags saturation.
    always_comb begin
        txn_sum   = {1'b0, txn_cnt_q} + 17'(b_hs) + 17'(r_hs && r_last && r_plain);
        txn_cnt_d = txn_sum[16] ? 16'hFFFF : txn_sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_id_q    <= '0;
            r_id_q    <= '0;
            r_cnt_q   <= 8'd0;
            txn_cnt_q <= 16'd0;
`ifdef PB_AXI_ERR_RSP_ATOP_EN
            atop_pend_q <= 1'b0;
            r_atop_q    <= 1'b0;
            atop_id_q   <= '0;
            atop_len_q  <= 8'd0;
`endif
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_id_q    <= w_id_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
            txn_cnt_q <= txn_cnt_d;
`ifdef PB_AXI_ERR_RSP_ATOP_EN
            atop_pend_q <= atop_pend_d;
            r_atop_q    <= r_atop_d;
            atop_id_q   <= atop_id_d;
            atop_len_q  <= atop_len_d;
`endif
        end
    end

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_ready;
        axi_rsp_o.w_ready  = w_ready;
        axi_rsp_o.ar_ready = ar_ready;
        axi_rsp_o.b_valid  = b_valid;
        axi_rsp_o.r_valid  = r_valid;
        if (w_state_q == W_RESP) begin
            axi_rsp_o.b.id   = w_id_q;
            axi_rsp_o.b.resp = RespCode;
        end
        if (r_state_q == R_DATA) begin
            axi_rsp_o.r.id   = r_id_q;
            axi_rsp_o.r.data = RDataExt;
            axi_rsp_o.r.resp = RespCode;
            axi_rsp_o.r.last = r_last;
        end
    end

    assign busy_o    = (w_state_q != W_IDLE) || (r_state_q != R_IDLE) || atop_pend;
    assign txn_cnt_o = txn_cnt_q;

endmodule
